fmul_share_ctrl: RTL and testbench

- Round-robin controller that shares one pipelined IEEE single-precision multiplier (E8/M23, PIPE_LAT register stages, stall-gated) among NREQ requesters.
- Accepts operand pairs over valid/ready, drives the multiplier's a/b/rm inputs and its astall, and tracks requester tags in a shadow valid/tag pipeline matched to the multiplier latency.
- Returns each tagged result on a single valid/ready result port.
- Applies full back-pressure by freezing the multiplier pipe.

---
 rtl/fmul_share_pkg.sv | 39 +++
 rtl/fmul_rr_arb.sv | 54 +++++
 rtl/fmul_share_ctrl.sv | 114 +++++++++++
 tb/tb_fmul_share_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_share_pkg.sv
// Shared types and constants for the shared single-precision multiplier controller.
// Holds IEEE single field layout, rounding-mode encodings and the operand payload struct.
package fmul_share_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned TAG_W_DEF = $clog2(NREQ_DEF);

  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam int unsigned SIGN_POS = 31;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MAN_LSB  = 0;
  localparam int unsigned RM_W     = 3;

  typedef enum logic [RM_W-1:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Split a raw 32-bit word into sign/exponent/mantissa fields.
  function automatic fp32_t unpack_fp(input logic [FP_W-1:0] w);
    fp32_t f;
    f.sign = w[SIGN_POS];
    f.exp  = w[EXP_LSB +: EXP_W];
    f.man  = w[MAN_LSB +: MAN_W];
    return f;
  endfunction

endpackage

// File: rtl/fmul_rr_arb.sv
// Round-robin arbiter: grants the lowest requester at or after the pointer, wrapping.
// The pointer advances past the winner only when a grant is made while enabled.
module fmul_rr_arb
  import fmul_share_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned TAG_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [TAG_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] ptr_nxt;

  // Priority search starting at the pointer.
  always_comb begin
    int unsigned      j;
    logic [TAG_W-1:0] jj;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    jj      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      jj = TAG_W'(j);
      if (en && !gnt_any && req[jj]) begin
        gnt_any = 1'b1;
        gnt_idx = jj;
        gnt[jj] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (gnt_any) begin
      ptr_nxt = (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

endmodule

// File: rtl/fmul_share_ctrl.sv
// Shares one pipelined single-precision multiplier among NREQ requesters, tracking
// requester tags in a shadow pipe that freezes together with the multiplier on back-pressure.
module fmul_share_ctrl
  import fmul_share_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned PIPE_LAT = 1,
  parameter int unsigned TAG_W    = $clog2(NREQ)
) (
  input  logic                           aclk,
  input  logic                           arst_n,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ*FP_W-1:0]           req_a,
  input  logic [NREQ*FP_W-1:0]           req_b,
  input  logic [NREQ*RM_W-1:0]           req_rm,
  output logic                           mul_a_sign,
  output logic [EXP_W-1:0]               mul_a_exp,
  output logic [MAN_W-1:0]               mul_a_man,
  output logic                           mul_b_sign,
  output logic [EXP_W-1:0]               mul_b_exp,
  output logic [MAN_W-1:0]               mul_b_man,
  output logic [RM_W-1:0]                mul_rm,
  output logic                           mul_astall,
  input  logic [FP_W-1:0]                mul_x,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [FP_W-1:0]                res_data,
  output logic [TAG_W-1:0]               res_tag,
  output logic                           busy,
  output logic [$clog2(PIPE_LAT+1):0]    inflight
);

  localparam int unsigned INF_W = $clog2(PIPE_LAT + 1) + 1;

  logic             stall;
  logic [NREQ-1:0]  gnt;
  logic [TAG_W-1:0] gnt_idx;
  logic             gnt_any;
  fp32_t            op_a;
  fp32_t            op_b;
  logic [RM_W-1:0]  op_rm;

  logic [PIPE_LAT-1:0] sh_valid;
  logic [TAG_W-1:0]    sh_tag [PIPE_LAT];
  logic [INF_W-1:0]    cnt;

  // A bubble at the output can never stall, so only a held result freezes the pipe.
  assign stall      = res_valid & ~res_ready;
  assign mul_astall = stall;

  fmul_rr_arb #(
    .NREQ  (NREQ),
    .TAG_W (TAG_W)
  ) u_arb (
    .clk     (aclk),
    .rst_n   (arst_n),
    .en      (!stall),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  // Steer the winner's operands; zero when nothing is granted.
  always_comb begin
    op_a  = '0;
    op_b  = '0;
    op_rm = '0;
    if (gnt_any) begin
      op_a  = unpack_fp(req_a[FP_W*32'(gnt_idx) +: FP_W]);
      op_b  = unpack_fp(req_b[FP_W*32'(gnt_idx) +: FP_W]);
      op_rm = req_rm[RM_W*32'(gnt_idx) +: RM_W];
    end
  end

  assign mul_a_sign = op_a.sign;
  assign mul_a_exp  = op_a.exp;
  assign mul_a_man  = op_a.man;
  assign mul_b_sign = op_b.sign;
  assign mul_b_exp  = op_b.exp;
  assign mul_b_man  = op_b.man;
  assign mul_rm     = op_rm;

  // Shadow {valid, tag} pipe, advanced in lockstep with the multiplier stages.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      sh_valid <= '0;
      for (int unsigned k = 0; k < PIPE_LAT; k++) sh_tag[k] <= '0;
    end else if (!stall) begin
      sh_valid[0] <= gnt_any;
      sh_tag[0]   <= gnt_idx;
      for (int unsigned k = 1; k < PIPE_LAT; k++) begin
        sh_valid[k] <= sh_valid[k-1];
        sh_tag[k]   <= sh_tag[k-1];
      end
    end
  end

  assign res_valid = sh_valid[PIPE_LAT-1];
  assign res_tag   = sh_tag[PIPE_LAT-1];
  assign res_data  = mul_x;

  always_comb begin
    cnt = '0;
    for (int unsigned k = 0; k < PIPE_LAT; k++) cnt = cnt + INF_W'(sh_valid[k]);
  end

  assign inflight = cnt;
  assign busy     = (cnt != '0);

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Scoreboard bench for fmul_share_ctrl with a stall-gated behavioural multiplier attached.
// Stimulus pushes hand-computed results; a negedge monitor pops and compares on each accept.
module tb_fmul_share_ctrl;
  import fmul_share_pkg::*;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned PIPE_LAT = 2;
  localparam int unsigned TAG_W    = 2;
  localparam int unsigned INF_W    = $clog2(PIPE_LAT + 1) + 1;

  logic                 aclk;
  logic                 arst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic [NREQ*3-1:0]    req_rm;
  logic                 mul_a_sign, mul_b_sign;
  logic [7:0]           mul_a_exp, mul_b_exp;
  logic [22:0]          mul_a_man, mul_b_man;
  logic [2:0]           mul_rm;
  logic                 mul_astall;
  logic [31:0]          mul_x;
  logic                 res_valid;
  logic                 res_ready;
  logic [31:0]          res_data;
  logic [TAG_W-1:0]     res_tag;
  logic                 busy;
  logic [INF_W-1:0]     inflight;

  fmul_share_ctrl #(
    .NREQ     (NREQ),
    .PIPE_LAT (PIPE_LAT),
    .TAG_W    (TAG_W)
  ) dut (
    .aclk       (aclk),
    .arst_n     (arst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rm     (req_rm),
    .mul_a_sign (mul_a_sign),
    .mul_a_exp  (mul_a_exp),
    .mul_a_man  (mul_a_man),
    .mul_b_sign (mul_b_sign),
    .mul_b_exp  (mul_b_exp),
    .mul_b_man  (mul_b_man),
    .mul_rm     (mul_rm),
    .mul_astall (mul_astall),
    .mul_x      (mul_x),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .busy       (busy),
    .inflight   (inflight)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Normal-number multiply with truncation; the test operands give exact products.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int          ee;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    ee = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m  = p[46:24];
      ee = ee + 1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], 8'(ee), m};
  endfunction

  logic [31:0] mx [PIPE_LAT];
  assign mul_x = mx[PIPE_LAT-1];

  always @(posedge aclk) begin
    if (!mul_astall) begin
      mx[0] <= fp_mul({mul_a_sign, mul_a_exp, mul_a_man}, {mul_b_sign, mul_b_exp, mul_b_man});
      for (int k = 1; k < PIPE_LAT; k++) mx[k] <= mx[k-1];
    end
  end

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] fdat [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic neg();
    @(negedge aclk);
  endtask

  task automatic push(input int tag, input logic [31:0] data);
    exp_t e;
    e.tag  = TAG_W'(tag);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_rm[i*3 +: 3]  = 3'(RM_RNE);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 30) begin
      cyc();
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Monitor: every accepted result must match the oldest expectation.
  always @(negedge aclk) begin
    if (arst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got tag %0d data 0x%08h, required none", res_tag, res_data);
      end else begin
        mon_e = sb.pop_front();
        chk("res_tag", 32'(res_tag), 32'(mon_e.tag));
        chk("res_data", res_data, mon_e.data);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fdat[0] = 32'h40400000;  // 1.0 * 3.0
    fdat[1] = 32'h3F800000;  // 2.0 * 0.5
    fdat[2] = 32'h40100000;  // 1.5 * 1.5
    fdat[3] = 32'hC0400000;  // -2.0 * 1.5
    arst_n    = 1'b0;
    res_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_rm    = '0;

    repeat (2) cyc();
    neg();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_astall", 32'(mul_astall), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    cyc();
    arst_n = 1'b1;
    cyc();

    // Single op from requester 0
    set_op(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    push(0, 32'h40000000);
    neg();
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    chk("t1_a_exp", 32'(mul_a_exp), 32'd127);
    chk("t1_b_exp", 32'(mul_b_exp), 32'd128);
    chk("t1_b_man", 32'(mul_b_man), 32'd0);
    chk("t1_rm", 32'(mul_rm), 32'(RM_RNE));
    cyc();
    req_valid = '0;
    neg();
    chk("t1_valid_early", 32'(res_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_inflight", 32'(inflight), 32'd1);
    cyc();
    neg();
    chk("t1_valid_lat", 32'(res_valid), 32'd1);
    chk("t1_busy_last", 32'(busy), 32'd1);
    cyc();
    neg();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_valid", 32'(res_valid), 32'd0);

    // Move the pointer back to 0 via a lone grant to requester 3
    cyc();
    set_op(3, 32'h40000000, 32'h40000000);
    req_valid = 4'b1000;
    push(3, 32'h40800000);
    neg();
    chk("prime_req_ready", 32'(req_ready), 32'h8);
    cyc();
    req_valid = '0;
    wait_idle();

    // Fairness: all four requesting for eight cycles
    set_op(0, 32'h3F800000, 32'h40400000);
    set_op(1, 32'h40000000, 32'h3F000000);
    set_op(2, 32'h3FC00000, 32'h3FC00000);
    set_op(3, 32'hC0000000, 32'h3FC00000);
    for (int k = 0; k < 10; k++) begin
      cyc();
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      if (k < 8) push(k % 4, fdat[k % 4]);
      neg();
      if (k < 8) chk("fair_grant", 32'(req_ready), 32'(1) << (k % 4));
      chk("fair_res_valid", 32'(res_valid), (k >= 2) ? 32'd1 : 32'd0);
      chk("fair_astall", 32'(mul_astall), 32'd0);
      if (k == 4) chk("fair_inflight", 32'(inflight), 32'd2);
    end
    cyc();
    wait_idle();

    // Back-pressure: result from requester 2 held for three cycles
    set_op(2, 32'h3FC00000, 32'h3FC00000);
    req_valid = 4'b0100;
    push(2, 32'h40100000);
    neg();
    chk("bp_grant", 32'(req_ready), 32'h4);
    cyc();
    req_valid = '0;
    res_ready = 1'b0;
    set_op(1, 32'h40000000, 32'h3F000000);
    neg();
    chk("bp_valid_early", 32'(res_valid), 32'd0);
    for (int s = 0; s < 3; s++) begin
      cyc();
      req_valid = 4'b0010;
      neg();
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_data", res_data, 32'h40100000);
      chk("bp_hold_tag", 32'(res_tag), 32'd2);
      chk("bp_astall", 32'(mul_astall), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_zero_ops", 32'(mul_b_exp), 32'd0);
    end
    cyc();
    res_ready = 1'b1;
    push(1, 32'h3F800000);
    neg();
    chk("bp_release_grant", 32'(req_ready), 32'h2);
    chk("bp_release_astall", 32'(mul_astall), 32'd0);
    cyc();
    req_valid = '0;
    neg();
    chk("bp_no_dup", 32'(res_valid), 32'd0);
    cyc();
    neg();
    chk("bp_next_valid", 32'(res_valid), 32'd1);
    wait_idle();

    // Mixed bubbles: requester 1 on alternate cycles
    for (int k = 0; k < 10; k++) begin
      cyc();
      req_valid = (k < 8 && (k % 2) == 0) ? 4'b0010 : 4'b0000;
      if (k < 8 && (k % 2) == 0) push(1, 32'h3F800000);
      neg();
      chk("mix_grant", 32'(req_ready), (k < 8 && (k % 2) == 0) ? 32'h2 : 32'h0);
      chk("mix_res_valid", 32'(res_valid), (k >= 2 && (k % 2) == 0) ? 32'd1 : 32'd0);
      chk("mix_astall", 32'(mul_astall), 32'd0);
    end
    cyc();
    wait_idle();

    // Wrap: pointer to 3, then requesters 3 and 0, then 0 and 1
    req_valid = 4'b0100;
    push(2, 32'h40100000);
    neg();
    chk("wrap_setup", 32'(req_ready), 32'h4);
    cyc();
    set_op(3, 32'hC0000000, 32'h3FC00000);
    set_op(0, 32'h3F800000, 32'h40400000);
    req_valid = 4'b1001;
    push(3, 32'hC0400000);
    neg();
    chk("wrap_g3", 32'(req_ready), 32'h8);
    cyc();
    push(0, 32'h40400000);
    neg();
    chk("wrap_g0", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 4'b0011;
    push(1, 32'h3F800000);
    neg();
    chk("wrap_ptr1", 32'(req_ready), 32'h2);
    cyc();
    req_valid = '0;
    wait_idle();

    // Reset with one op stalled at the output
    res_ready = 1'b0;
    set_op(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    cyc();
    neg();
    chk("rstmid_valid_pre", 32'(res_valid), 32'd1);
    chk("rstmid_astall_pre", 32'(mul_astall), 32'd1);
    cyc();
    arst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(res_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_inflight", 32'(inflight), 32'd0);
    chk("rstmid_astall", 32'(mul_astall), 32'd0);
    cyc();
    arst_n    = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      neg();
      chk("rstmid_no_result", 32'(res_valid), 32'd0);
      cyc();
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
